// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the MEM-stage load/store unit:
//   - lsu_state_e : access sequencer states
//   - F3_*        : RV32 load/store width/sign codes
//   - ERR_*       : completion error codes reported alongside done
//   - f3_illegal / f3_misaligned : request legality checks applied at acceptance
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Unsigned variants exist only for loads; 011/110/111 are never legal.
  function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
    logic ill;
    case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = st;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Halves need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = lo[0];
      F3_W:        mis = (lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane steering for the load/store unit.
//   funct3      in  3     access width/sign code
//   addr_lo     in  2     byte offset within the bus word
//   wdata       in  XLEN  store data, LSB-aligned
//   rdata       in  XLEN  raw bus read word
//   be          out 4     byte enables for the access
//   wdata_lanes out XLEN  store data replicated across all lanes of its width
//   load_data   out XLEN  selected byte/half/word, sign- or zero-extended
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_lanes,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted_s;

  // Byte enables, store replication and load extraction/extension.
  always_comb begin
    // Bring the addressed lane down to bit 0; word accesses have offset 0.
    shifted_s   = rdata >> {addr_lo, 3'b000};
    be          = 4'b0000;
    wdata_lanes = {XLEN{1'b0}};
    load_data   = {XLEN{1'b0}};
    case (funct3)
      F3_B, F3_BU: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        if (funct3[2]) begin
          load_data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
        end else begin
          load_data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      F3_H, F3_HU: begin
        be          = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
        if (funct3[2]) begin
          load_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
        end else begin
          load_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      F3_W: begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        load_data   = shifted_s;
      end
      default: begin
        be          = 4'b0000;
        wdata_lanes = {XLEN{1'b0}};
        load_data   = {XLEN{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store unit: accepts one access from execute, checks it,
// runs it on a request/grant/response bus and reports completion.
//   clk, resetn                  clock, async active-low reset
//   en/is_store/funct3/addr/wdata request from execute (taken when busy=0)
//   busy, done, err, rdata        status and load result (valid with done)
//   bus_req/we/addr/be/wdata      registered bus request
//   bus_gnt, bus_rvalid, bus_rdata bus handshake and read data
// -----------------------------------------------------------------------------
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [XLEN-1:0]   rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  if (XLEN != 32) begin : g_xlen_check
    $error("mem_access_unit: XLEN must be 32");
  end
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("mem_access_unit: TIMEOUT must be at least 2");
  end

  lsu_state_e      state_r;
  logic            is_store_r;
  logic [2:0]      funct3_r;
  logic [1:0]      addr_lo_r;
  logic [CW-1:0]   cnt_r;

  logic [2:0]      f3_s;
  logic [1:0]      lo_s;
  logic            illegal_s;
  logic            misalign_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_lanes_s;
  logic [XLEN-1:0] load_data_s;

  // Steer the aligner from the live request in IDLE, from the latched one otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      f3_s = funct3;
      lo_s = addr[1:0];
    end else begin
      f3_s = funct3_r;
      lo_s = addr_lo_r;
    end
    illegal_s  = f3_illegal(is_store, funct3);
    misalign_s = f3_misaligned(funct3, addr[1:0]);
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3      (f3_s),
    .addr_lo     (lo_s),
    .wdata       (wdata),
    .rdata       (bus_rdata),
    .be          (be_s),
    .wdata_lanes (wdata_lanes_s),
    .load_data   (load_data_s)
  );

  // Access sequencer with all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      is_store_r <= 1'b0;
      funct3_r   <= 3'b000;
      addr_lo_r  <= 2'b00;
      cnt_r      <= {CW{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_OK;
      rdata      <= {XLEN{1'b0}};
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= {ADDR_W{1'b0}};
      bus_be     <= 4'b0000;
      bus_wdata  <= {XLEN{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            busy       <= 1'b1;
            is_store_r <= is_store;
            funct3_r   <= funct3;
            addr_lo_r  <= addr[1:0];
            rdata      <= {XLEN{1'b0}};
            err        <= ERR_OK;
            // Rejected requests finish without touching the bus.
            if (illegal_s) begin
              err     <= ERR_ILLEGAL;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else if (misalign_s) begin
              err     <= ERR_MISALIGN;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= be_s;
              bus_wdata <= wdata_lanes_s;
              cnt_r     <= {CW{1'b0}};
              state_r   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // A grant wins over a same-cycle rvalid, which is simply not looked at here.
          if (bus_gnt) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (is_store_r) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              cnt_r   <= {CW{1'b0}};
              state_r <= ST_RESP;
            end
          end else if (cnt_r == TO_LAST) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            err     <= ERR_TIMEOUT;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RESP: begin
          if (bus_rvalid) begin
            rdata   <= load_data_s;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else if (cnt_r == TO_LAST) begin
            err     <= ERR_TIMEOUT;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Scoreboard bench: the driver predicts each access from the ISA rules and
// queues the expected completion; a monitor pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .en(en), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    bit          chk_rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_err", {30'd0, err}, {30'd0, e.err});
        chk("done_cycle", cyc, e.cyc);
        if (e.chk_rd) chk("done_rdata", rdata, e.rdata);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit ref_legal(bit st, int f3);
    if (st) return (f3 == 0 || f3 == 1 || f3 == 2);
    return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
  endfunction

  function automatic int ref_bytes(int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [31:0] ref_load(int f3, int off, logic [31:0] rd);
    longint v;
    int n;
    n = ref_bytes(f3);
    v = longint'(rd) >> (8 * off);
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (f3 < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wlanes(int f3, logic [31:0] wd);
    int n;
    n = ref_bytes(f3);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // Random request while busy: must be ignored.
  task automatic junk_en();
    en       = 1'($urandom % 2);
    is_store = 1'($urandom % 2);
    funct3   = 3'($urandom % 8);
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  task automatic do_access(input bit st, input int f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int gd, input int rv, input bit no_gnt, input bit no_rv);
    exp_t e;
    int n, off;
    logic [3:0] be_exp;
    n   = ref_bytes(f3);
    off = int'(a[1:0]);
    be_exp = 4'(((1 << n) - 1) << off);
    e.chk_rd = 1'b0;
    e.rdata  = 32'h0;
    if (!ref_legal(st, f3)) begin
      e.err = 2'b11; e.cyc = cyc + 1;
    end else if (off % n != 0) begin
      e.err = 2'b01; e.cyc = cyc + 1;
    end else if (no_gnt) begin
      e.err = 2'b10; e.cyc = cyc + 1 + TO;
    end else if (!st && no_rv) begin
      e.err = 2'b10; e.cyc = cyc + 2 + gd + TO;
    end else if (st) begin
      e.err = 2'b00; e.cyc = cyc + 2 + gd;
    end else begin
      e.err = 2'b00; e.cyc = cyc + 2 + gd + rv;
      e.chk_rd = 1'b1; e.rdata = ref_load(f3, off, rd);
    end
    exp_q.push_back(e);
    en = 1'b1; is_store = st; funct3 = 3'(f3); addr = a; wdata = wd;
    @(negedge clk);
    en = 1'b0;
    if (e.err == 2'b11 || e.err == 2'b01) begin
      chk("rej_no_req", {31'd0, bus_req}, 32'd0);
      junk_en();
      @(negedge clk);
      en = 1'b0;
      wait_idle();
      return;
    end
    chk("req_up", {31'd0, bus_req}, 32'd1);
    chk("req_we", {31'd0, bus_we}, {31'd0, st});
    chk("req_addr", bus_addr, {a[31:2], 2'b00});
    chk("req_be", {28'd0, bus_be}, {28'd0, be_exp});
    if (st) chk("req_wdata", bus_wdata, ref_wlanes(f3, wd));
    if (no_gnt) begin
      wait_idle();
      chk("to_req_low", {31'd0, bus_req}, 32'd0);
      return;
    end
    for (int i = 0; i < gd; i++) begin
      junk_en();
      @(negedge clk);
      chk("req_hold_addr", bus_addr, {a[31:2], 2'b00});
    end
    en = 1'b0;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = ~rd;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    chk("req_drop", {31'd0, bus_req}, 32'd0);
    if (!st && !no_rv) begin
      for (int i = 1; i < rv; i++) @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = rd;
      @(negedge clk);
      bus_rvalid = 1'b0; bus_rdata = $urandom;
    end
    wait_idle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_err"}, {30'd0, err}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_be"}, {28'd0, bus_be}, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
  endtask

  // Abort a load mid-flight; no completion is queued because none may appear.
  task automatic reset_mid(input bit in_resp);
    en = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500; wdata = 32'h0;
    @(negedge clk);
    en = 1'b0;
    chk("rst_pre_req", {31'd0, bus_req}, 32'd1);
    if (in_resp) begin
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
    end
    resetn = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("rst_mid");
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_access(1'b1, 2, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b1, 0, 32'h203, 32'h000000A5, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b0, 0, 32'h301, 32'h0, 32'h12348056, 0, 2, 1'b0, 1'b0);
    do_access(1'b0, 4, 32'h301, 32'h0, 32'h12348056, 0, 2, 1'b0, 1'b0);
    do_access(1'b0, 5, 32'h302, 32'h0, 32'h12348056, 1, 1, 1'b0, 1'b0);
    do_access(1'b0, 2, 32'h402, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b0, 3, 32'h400, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b1, 4, 32'h400, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b1, 1, 32'h601, 32'h1234, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b0, 2, 32'h700, 32'h0, 32'h0, 0, 1, 1'b1, 1'b0);
    do_access(1'b0, 1, 32'h702, 32'h0, 32'h0, 2, 1, 1'b0, 1'b1);

    reset_mid(1'b1);
    do_access(1'b0, 2, 32'h800, 32'h0, 32'hCAFEF00D, 0, 1, 1'b0, 1'b0);
    reset_mid(1'b0);
    do_access(1'b1, 2, 32'h804, 32'h89ABCDEF, 32'h0, 0, 1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 120; k++) begin
      do_access(1'($urandom % 2), int'($urandom % 8), $urandom, $urandom, $urandom,
                int'($urandom % 4), 1 + int'($urandom % 3), 1'b0, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
